// File: rtl/ifetch_stage_pkg.sv
// Shared encodings for the MIPS-lite fetch stage: FSM state codes, opcode fields, reset PC.
package ifetch_stage_pkg;

    localparam logic [1:0] IF_STATE_REQ  = 2'd0;
    localparam logic [1:0] IF_STATE_WAIT = 2'd1;
    localparam logic [1:0] IF_STATE_HOLD = 2'd2;
    localparam logic [1:0] IF_STATE_KILL = 2'd3;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    function automatic logic [5:0] op_field(input logic [31:0] word);
        return word[31:26];
    endfunction

endpackage

// File: rtl/ifetch_stage_next_pc_calc.sv
// Combinational next-PC logic: sequential PC, BEQ target, J/JAL target and redirect select.
module next_pc_calc
    import ifetch_stage_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [15:0]       br_imm,
    input  logic              jmp,
    input  logic [25:0]       jmp_index,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              redirect,
    output logic [ADDR_W-1:0] target
);
    logic [ADDR_W-1:0] br_seq;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] jmp_target;

    assign pc_plus4   = pc + ADDR_W'(4);
    assign br_seq     = br_pc + ADDR_W'(4);
    assign br_target  = br_seq + {{(ADDR_W-18){br_imm[15]}}, br_imm, 2'b00};
    // The jump region comes from the delay-slot PC of the jump itself.
    assign jmp_target = {br_seq[ADDR_W-1:28], jmp_index, 2'b00};
    assign redirect   = jmp | br_taken;
    assign target     = jmp ? jmp_target : br_target;

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: owns the PC, fetches one word at a time, hands {instr, pc, op} to decode.
// IFETCH_SKID_EN adds a one-entry skid buffer so fetch can run at one instruction per cycle.
module ifetch_stage
    import ifetch_stage_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(PC_RESET_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [5:0]        op,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [15:0]       br_imm,
    input  logic              jmp,
    input  logic [25:0]       jmp_index
);
    typedef struct packed {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] pc;
    } fetch_ent_t;

    logic [1:0]        state, state_nx;
    logic [ADDR_W-1:0] pc, fetch_pc, pc_plus4, redir_pc;
    logic              redirect, req_fire, rsp_take, accept, outstanding_nx;
    fetch_ent_t        out_q, rsp_ent;
    logic              out_v;
`ifdef IFETCH_SKID_EN
    fetch_ent_t        skid_q;
    logic              skid_v;
`endif

    next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
        .pc        (pc),
        .br_taken  (br_taken),
        .br_pc     (br_pc),
        .br_imm    (br_imm),
        .jmp       (jmp),
        .jmp_index (jmp_index),
        .pc_plus4  (pc_plus4),
        .redirect  (redirect),
        .target    (redir_pc)
    );

    assign accept   = out_v & instr_ready;
    assign rsp_take = imem_rsp_valid & (state == IF_STATE_WAIT) & ~redirect;
    assign rsp_ent  = '{instr: imem_rsp_data, pc: fetch_pc};

`ifdef IFETCH_SKID_EN
    // Reissue in the response cycle only if that response is guaranteed a slot in the output register.
    assign imem_req_valid = ~rst & (((state == IF_STATE_REQ) & ~skid_v) |
                                    ((state == IF_STATE_WAIT) & imem_rsp_valid & ~redirect &
                                     (~out_v | instr_ready)));
`else
    assign imem_req_valid = ~rst & (state == IF_STATE_REQ);
`endif
    assign req_fire  = imem_req_valid & imem_req_ready;
    assign imem_addr = pc;

    // A request is still in flight after this edge if an old one has not returned or a new one fired.
    assign outstanding_nx = (((state == IF_STATE_WAIT) | (state == IF_STATE_KILL)) & ~imem_rsp_valid)
                          | req_fire;

    always_comb begin
        state_nx = state;
        if (redirect) begin
            state_nx = outstanding_nx ? IF_STATE_KILL : IF_STATE_REQ;
        end else begin
            case (state)
                IF_STATE_REQ:  if (req_fire) state_nx = IF_STATE_WAIT;
`ifdef IFETCH_SKID_EN
                IF_STATE_WAIT: if (imem_rsp_valid) state_nx = req_fire ? IF_STATE_WAIT : IF_STATE_REQ;
`else
                IF_STATE_WAIT: if (imem_rsp_valid) state_nx = IF_STATE_HOLD;
`endif
                IF_STATE_HOLD: if (accept) state_nx = IF_STATE_REQ;
                IF_STATE_KILL: if (imem_rsp_valid) state_nx = IF_STATE_REQ;
                default:       state_nx = IF_STATE_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IF_STATE_REQ;
            pc       <= PC_RESET;
            fetch_pc <= '0;
            out_q    <= '0;
            out_v    <= 1'b0;
`ifdef IFETCH_SKID_EN
            skid_q   <= '0;
            skid_v   <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (redirect)      pc <= redir_pc;
            else if (req_fire) pc <= pc_plus4;
            if (req_fire) fetch_pc <= pc;

            if (redirect) begin
                out_v <= 1'b0;
`ifdef IFETCH_SKID_EN
                skid_v <= 1'b0;
`endif
            end else begin
                if (accept) out_v <= 1'b0;
`ifdef IFETCH_SKID_EN
                if (accept && skid_v) begin
                    out_q  <= skid_q;
                    out_v  <= 1'b1;
                    skid_v <= 1'b0;
                end
                // skid is always empty while waiting, so a response never competes with it
                if (rsp_take) begin
                    if (!out_v || accept) begin
                        out_q <= rsp_ent;
                        out_v <= 1'b1;
                    end else begin
                        skid_q <= rsp_ent;
                        skid_v <= 1'b1;
                    end
                end
`else
                if (rsp_take) begin
                    out_q <= rsp_ent;
                    out_v <= 1'b1;
                end
`endif
            end
        end
    end

    assign instr_valid = out_v;
    assign instr       = out_q.instr;
    assign instr_pc    = out_q.pc;
    assign op          = op_field(out_q.instr);

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage with a one-outstanding memory model of programmable latency.
module tb_ifetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr, instr_pc;
    logic [5:0]  op;
    logic        br_taken = 1'b0;
    logic [31:0] br_pc    = '0;
    logic [15:0] br_imm   = '0;
    logic        jmp      = 1'b0;
    logic [25:0] jmp_index = '0;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          rsp_lat = 0;
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;
    logic [31:0] req_log[$];

`ifdef IFETCH_SKID_EN
    localparam int HOLD_REQS = 5;
`else
    localparam int HOLD_REQS = 4;
`endif

    always #5 clk = ~clk;

    ifetch_stage dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc), .op(op),
        .br_taken(br_taken), .br_pc(br_pc), .br_imm(br_imm), .jmp(jmp), .jmp_index(jmp_index)
    );

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {a[7:2], a[25:0]};
    endfunction

    always @(posedge clk) begin : mem_model
        logic        hs;
        logic [31:0] a;
        hs = imem_req_valid && imem_req_ready;
        a  = imem_addr;
        #1;
        imem_rsp_valid = 1'b0;
        if (hs) begin
            pend = 1'b1; pend_addr = a; pend_cnt = rsp_lat; req_log.push_back(a);
        end else if (pend && pend_cnt > 0) begin
            pend_cnt--;
        end
        if (pend && pend_cnt == 0) begin
            imem_rsp_valid = 1'b1; imem_rsp_data = memw(pend_addr); pend = 1'b0;
        end
    end

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (instr_valid) begin ok = 1'b1; break; end
        end
    endtask

    // want_rsp=1: a response cycle; want_rsp=0: a cycle with a request in flight and no response.
    task automatic wait_slot(input bit want_rsp, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (want_rsp ? imem_rsp_valid : (pend && !imem_rsp_valid)) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_instr_valid: got %b want 0", instr_valid); end
        n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL rst_instr: got %h want 0", instr); end
        n_cmp++; if (instr_pc !== 32'h0) begin n_bad++; $display("FAIL rst_instr_pc: got %h want 0", instr_pc); end
        n_cmp++; if (imem_addr !== 32'h3000) begin n_bad++; $display("FAIL rst_pc: got %h want 3000", imem_addr); end
    endtask

    task automatic test_sequential;
        bit          ok;
        logic [31:0] e;
        req_log.delete();
        rst = 1'b0;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL rel_req_valid: got %b want 1", imem_req_valid); end
        for (int k = 0; k < 3; k++) begin
            e = 32'h3000 + 32'(4 * k);
            wait_valid(ok);
            n_cmp++; if (!ok || instr_pc !== e) begin n_bad++; $display("FAIL seq_pc%0d: got %h want %h", k, instr_pc, e); end
            n_cmp++; if (instr !== memw(e)) begin n_bad++; $display("FAIL seq_instr%0d: got %h want %h", k, instr, memw(e)); end
            n_cmp++; if (op !== e[7:2]) begin n_bad++; $display("FAIL seq_op%0d: got %h want %h", k, op, e[7:2]); end
        end
        for (int k = 0; k < 3; k++) begin
            e = 32'h3000 + 32'(4 * k);
            n_cmp++;
            if (req_log.size() <= k || req_log[k] !== e) begin
                n_bad++; $display("FAIL seq_addr%0d: got %h want %h", k, (req_log.size() > k) ? req_log[k] : 32'hx, e);
            end
        end
    endtask

    task automatic test_stall;
        bit          ok;
        logic [31:0] held;
        @(negedge clk);
        instr_ready = 1'b0;
        wait_valid(ok);
        held = instr;
        n_cmp++; if (!ok || instr_pc !== 32'h300c) begin n_bad++; $display("FAIL stall_pc: got %h want 300c", instr_pc); end
        repeat (5) begin
            @(negedge clk);
            n_cmp++;
            if (instr_valid !== 1'b1 || instr !== held || instr_pc !== 32'h300c) begin
                n_bad++; $display("FAIL stall_hold: got v=%b %h@%h want v=1 %h@300c", instr_valid, instr, instr_pc, held);
            end
        end
        n_cmp++; if (req_log.size() != HOLD_REQS) begin n_bad++; $display("FAIL stall_reqs: got %0d want %0d", req_log.size(), HOLD_REQS); end
        instr_ready = 1'b1;
        wait_valid(ok);
        n_cmp++; if (!ok || instr_pc !== 32'h3010) begin n_bad++; $display("FAIL stall_resume: got %h want 3010", instr_pc); end
        n_cmp++; if (req_log.size() < 5 || req_log[4] !== 32'h3010) begin n_bad++; $display("FAIL stall_resume_req: got %0d reqs want req[4]=3010", req_log.size()); end
    endtask

    task automatic test_branch;
        bit ok, ok2;
        int n;
        rsp_lat = 2;
        wait_slot(1'b0, ok);
        n = req_log.size();
        br_taken = 1'b1; br_pc = 32'h3008; br_imm = 16'hfffe;
        @(negedge clk);
        n_cmp++; if (!ok || imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL br_kill_noreq: got %b want 0 (slot %b)", imem_req_valid, ok); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL br_flush: got %b want 0", instr_valid); end
        n_cmp++; if (imem_addr !== 32'h3004) begin n_bad++; $display("FAIL br_target: got %h want 3004", imem_addr); end
        br_taken = 1'b0;
        wait_valid(ok2);
        n_cmp++; if (!ok2 || instr_pc !== 32'h3004 || instr !== memw(32'h3004)) begin n_bad++; $display("FAIL br_instr: got %h@%h want %h@3004", instr, instr_pc, memw(32'h3004)); end
        n_cmp++; if (req_log.size() <= n || req_log[n] !== 32'h3004) begin n_bad++; $display("FAIL br_next_req: got %0d reqs want req[%0d]=3004", req_log.size(), n); end
    endtask

    task automatic test_jump;
        bit ok, ok2;
        wait_slot(1'b0, ok);
        jmp = 1'b1; jmp_index = 26'h0000c10; br_pc = 32'h0000_3010;
        @(negedge clk);
        n_cmp++; if (!ok || imem_addr !== 32'h3040) begin n_bad++; $display("FAIL jmp_target: got %h want 3040", imem_addr); end
        jmp = 1'b0;
        wait_valid(ok2);
        n_cmp++; if (!ok2 || instr_pc !== 32'h3040) begin n_bad++; $display("FAIL jmp_instr_pc: got %h want 3040", instr_pc); end
    endtask

    task automatic test_priority;
        bit ok, ok2;
        wait_slot(1'b0, ok);
        jmp = 1'b1; jmp_index = 26'h0000c20;
        br_taken = 1'b1; br_pc = 32'h3000; br_imm = 16'h0004;
        @(negedge clk);
        n_cmp++; if (!ok || imem_addr !== 32'h3080) begin n_bad++; $display("FAIL prio_target: got %h want 3080", imem_addr); end
        jmp = 1'b0; br_taken = 1'b0;
        wait_valid(ok2);
        n_cmp++; if (!ok2 || instr_pc !== 32'h3080) begin n_bad++; $display("FAIL prio_instr_pc: got %h want 3080", instr_pc); end
    endtask

    task automatic test_rsp_discard;
        bit ok, ok2;
        wait_slot(1'b1, ok);
        br_taken = 1'b1; br_pc = 32'h3100; br_imm = 16'h0010;
        @(negedge clk);
        n_cmp++; if (!ok || imem_req_valid !== 1'b1 || imem_addr !== 32'h3144) begin n_bad++; $display("FAIL disc_req: got v=%b %h want v=1 3144", imem_req_valid, imem_addr); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL disc_valid: got %b want 0", instr_valid); end
        br_taken = 1'b0;
        wait_valid(ok2);
        n_cmp++; if (!ok2 || instr_pc !== 32'h3144) begin n_bad++; $display("FAIL disc_instr_pc: got %h want 3144", instr_pc); end
    endtask

    task automatic test_reset_mid;
        bit ok, ok2;
        wait_slot(1'b0, ok);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (!ok || instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_valid: got iv=%b rv=%b want 0 0", instr_valid, imem_req_valid); end
        n_cmp++; if (imem_addr !== 32'h3000 || instr_pc !== 32'h0) begin n_bad++; $display("FAIL mrst_pc: got %h/%h want 3000/0", imem_addr, instr_pc); end
        @(negedge clk);
        req_log.delete();
        rst = 1'b0;
        wait_valid(ok2);
        n_cmp++; if (!ok2 || instr_pc !== 32'h3000 || instr !== memw(32'h3000)) begin n_bad++; $display("FAIL mrst_first: got %h@%h want %h@3000", instr, instr_pc, memw(32'h3000)); end
        n_cmp++; if (req_log.size() == 0 || req_log[0] !== 32'h3000) begin n_bad++; $display("FAIL mrst_req: got %0d reqs want req[0]=3000", req_log.size()); end
    endtask

`ifdef IFETCH_SKID_EN
    task automatic test_back_to_back;
        logic [31:0] p;
        rsp_lat = 0;
        repeat (10) @(negedge clk);
        p = instr_pc;
        n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_start: got %b want 1", instr_valid); end
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            n_cmp++;
            if (instr_valid !== 1'b1 || instr_pc !== p + 32'(4 * i)) begin
                n_bad++; $display("FAIL b2b_%0d: got v=%b %h want v=1 %h", i, instr_valid, instr_pc, p + 32'(4 * i));
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_jump();
        test_priority();
        test_rsp_discard();
        test_reset_mid();
`ifdef IFETCH_SKID_EN
        test_back_to_back();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1);
    end

endmodule
